// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Shares the write port of a single FIFO among NUM_REQ producers.
//            Grants are round-robin and burst based: a grant lasts until a
//            packet's last beat is written, MAX_BURST beats have been written,
//            or the granted producer drops its valid. Every grant costs one
//            arbitration (bubble) cycle. fifo_full is honoured combinationally
//            so that no write is ever issued into a full FIFO.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk            system clock, all state updates on the rising edge
//   reset          synchronous active-high reset
//   req_valid_i    per-producer beat valid                      [NUM_REQ]
//   req_data_i     per-producer beat, producer i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last_i     per-producer last-beat marker, qualified by valid
//   req_ready_o    per-producer accept (transfer on valid & ready)
//   fifo_full_i    FIFO full flag
//   fifo_wr_o      FIFO write strobe
//   fifo_w_data_o  FIFO write data
//   grant_id_o     index of the current (or most recent) grant holder
//   busy_o         high while a burst is in progress
// ============================================================================
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          fifo_full_i,
  output logic                          fifo_wr_o,
  output logic [DATA_WIDTH-1:0]         fifo_w_data_o,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id_o,
  output logic                          busy_o
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int                c_id_w      = $clog2(NUM_REQ);
  localparam int                c_cnt_w     = $clog2(MAX_BURST + 1);
  localparam logic [c_id_w-1:0] c_last_id   = c_id_w'(NUM_REQ - 1);
  localparam logic [c_id_w:0]   c_num_req   = (c_id_w + 1)'(NUM_REQ);
  localparam logic [c_cnt_w-1:0] c_max_burst = c_cnt_w'(MAX_BURST);

  // --------------------------------------------------------------------------
  // State machine encoding
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Registered state and next-state
  // --------------------------------------------------------------------------
  state_t              state_q,    state_d;
  logic [c_id_w-1:0]   grant_q,    grant_d;
  logic [c_id_w-1:0]   rr_ptr_q,   rr_ptr_d;
  logic [c_cnt_w-1:0]  beat_cnt_q, beat_cnt_d;

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] w_data_arr [NUM_REQ];
  logic                  w_grant_valid;
  logic                  w_grant_last;
  logic                  w_found;
  logic [c_id_w-1:0]     w_winner;
  logic [c_id_w:0]       w_scan_sum;
  logic [c_id_w-1:0]     w_scan_idx;
  logic [c_id_w-1:0]     w_next_ptr;
  logic [NUM_REQ-1:0]    w_ready;
  logic                  w_wr;
  logic                  w_release;

  // Split the flat data bus into one beat per producer so the output mux can
  // be a plain array index on the registered grant.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_data_arr[gi] = req_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign w_grant_valid = req_valid_i[grant_q];
  assign w_grant_last  = req_last_i[grant_q];

  // Pointer handed to the next arbitration after a release: one past the
  // current holder, wrapping explicitly so non-power-of-2 NUM_REQ never
  // produces an out-of-range index.
  assign w_next_ptr = (grant_q == c_last_id) ? '0 : grant_q + c_id_w'(1);

  // --------------------------------------------------------------------------
  // Round-robin scan: first valid requester at rr_ptr, rr_ptr+1, ... (mod N).
  // The sum is one bit wider than an index; both operands are < NUM_REQ so a
  // single conditional subtraction is enough to bring it back into range.
  // --------------------------------------------------------------------------
  always_comb begin
    w_found    = 1'b0;
    w_winner   = rr_ptr_q;
    w_scan_sum = '0;
    w_scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_scan_sum = {1'b0, rr_ptr_q} + (c_id_w + 1)'(k);
      if (w_scan_sum >= c_num_req) begin
        w_scan_sum = w_scan_sum - c_num_req;
      end
      w_scan_idx = w_scan_sum[c_id_w-1:0];
      if (!w_found && req_valid_i[w_scan_idx]) begin
        w_found  = 1'b1;
        w_winner = w_scan_idx;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and handshake logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    w_ready    = '0;
    w_wr       = 1'b0;
    w_release  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Arbitration cycle: nothing is accepted, the winner is registered
        // and owns the write port from the next cycle on.
        if (w_found) begin
          state_d    = ST_BURST;
          grant_d    = w_winner;
          beat_cnt_d = '0;
        end
      end

      ST_BURST: begin
        // Ready follows ~full even when the holder is not valid; a transfer
        // needs both, so this cannot cause a write on its own.
        w_ready[grant_q] = ~fifo_full_i;
        w_wr             = w_grant_valid & ~fifo_full_i;

        if (!w_grant_valid) begin
          // Holder went idle: give the port away without writing.
          w_release = 1'b1;
        end else if (w_wr) begin
          beat_cnt_d = beat_cnt_q + c_cnt_w'(1);
          // last and burst limit on the same beat collapse into one release.
          if (w_grant_last || (beat_cnt_d == c_max_burst)) begin
            w_release = 1'b1;
          end
        end
        // Valid but full: stall, count and grant held, last ignored.

        if (w_release) begin
          state_d  = ST_IDLE;
          rr_ptr_d = w_next_ptr;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. Write strobe and ready are squashed while reset is high so an
  // aborted burst cannot complete a beat in the reset cycle itself.
  // --------------------------------------------------------------------------
  assign req_ready_o   = reset ? '0 : w_ready;
  assign fifo_wr_o     = w_wr & ~reset;
  assign fifo_w_data_o = w_data_arr[grant_q];
  assign grant_id_o    = grant_q;
  assign busy_o        = (state_q == ST_BURST);

endmodule
`default_nettype wire
